// File: rtl/alu_fifo_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : alu_fifo_sequencer_if
// Purpose : Handshake/bus bundle between the button/mode front end, the FIFO
//           and ALU datapath, and the ALU FIFO sequencer.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
interface alu_fifo_sequencer_if #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 4
);
  logic              i_start;
  logic [OP_W-1:0]   i_opcode;
  logic              i_usr_wen;
  logic              i_usr_ren;
  logic              i_fifo_full;
  logic              i_fifo_empty;
  logic [CNT_W-1:0]  i_fifo_count;
  logic [DATA_W-1:0] i_fifo_rdata;
  logic [DATA_W-1:0] i_alu_result;

  logic              o_wen;
  logic              o_ren;
  logic [DATA_W-1:0] o_fifo_wdata;
  logic [DATA_W-1:0] o_alu_a;
  logic [DATA_W-1:0] o_alu_b;
  logic [OP_W-1:0]   o_alu_op;
  logic              o_busy;
  logic              o_usr_blocked;
  logic              o_done;
  logic              o_error;

  // Environment side: front end, FIFO and ALU
  modport master (
    output i_start, i_opcode, i_usr_wen, i_usr_ren, i_fifo_full, i_fifo_empty,
           i_fifo_count, i_fifo_rdata, i_alu_result,
    input  o_wen, o_ren, o_fifo_wdata, o_alu_a, o_alu_b, o_alu_op, o_busy,
           o_usr_blocked, o_done, o_error
  );

  // Sequencer side
  modport slave (
    input  i_start, i_opcode, i_usr_wen, i_usr_ren, i_fifo_full, i_fifo_empty,
           i_fifo_count, i_fifo_rdata, i_alu_result,
    output o_wen, o_ren, o_fifo_wdata, o_alu_a, o_alu_b, o_alu_op, o_busy,
           o_usr_blocked, o_done, o_error
  );
endinterface
`default_nettype wire

// File: rtl/alu_fifo_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : alu_fifo_sequencer
// Purpose : Pops two operands from the operand FIFO, runs one ALU op and pushes
//           the truncated result back, arbitrating FIFO access with the user.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module alu_fifo_sequencer #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 4
) (
  input  wire logic            clk,
  input  wire logic            reset,
  alu_fifo_sequencer_if.slave  bus
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_POP_A  = 4'd1;
  localparam logic [3:0] S_WAIT_A = 4'd2;
  localparam logic [3:0] S_POP_B  = 4'd3;
  localparam logic [3:0] S_WAIT_B = 4'd4;
  localparam logic [3:0] S_EXEC   = 4'd5;
  localparam logic [3:0] S_PUSH   = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_ERR    = 4'd8;

  logic [3:0]        r_state;
  logic [3:0]        w_next_state;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] r_result;

  logic w_enough;
  logic w_usr_req;
  logic w_busy;
  logic w_wen;
  logic w_ren;
  logic w_blocked;
  logic w_done;
  logic w_error;

  assign w_enough  = (bus.i_fifo_count >= CNT_W'(2));
  assign w_usr_req = bus.i_usr_wen | bus.i_usr_ren;
  assign w_busy    = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_op     <= '0;
      r_result <= '0;
    end else begin
      if ((r_state == S_IDLE) && bus.i_start && w_enough) begin
        r_op <= bus.i_opcode;
      end
      // Read data lands one cycle after Ren, i.e. while in the WAIT states
      if (r_state == S_WAIT_A) begin
        r_op_a <= bus.i_fifo_rdata;
      end
      if (r_state == S_WAIT_B) begin
        r_op_b <= bus.i_fifo_rdata;
      end
      if (r_state == S_EXEC) begin
        r_result <= bus.i_alu_result;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_next_state = w_enough ? S_POP_A : S_ERR;
        end
      end
      S_POP_A:  w_next_state = S_WAIT_A;
      S_WAIT_A: w_next_state = S_POP_B;
      S_POP_B:  w_next_state = S_WAIT_B;
      S_WAIT_B: w_next_state = S_EXEC;
      S_EXEC:   w_next_state = S_PUSH;
      S_PUSH:   w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      S_ERR:    w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_wen     = 1'b0;
    w_ren     = 1'b0;
    w_blocked = 1'b0;
    w_done    = 1'b0;
    w_error   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Pass-through depends on live inputs, so hold it off while reset is low
        if (reset) begin
          if (bus.i_start) begin
            w_blocked = w_usr_req;
          end else begin
            w_wen = bus.i_usr_wen & ~bus.i_fifo_full;
            w_ren = bus.i_usr_ren & ~bus.i_fifo_empty;
          end
        end
      end
      S_POP_A, S_POP_B: begin
        w_ren     = 1'b1;
        w_blocked = w_usr_req;
      end
      S_PUSH: begin
        w_wen     = 1'b1;
        w_blocked = w_usr_req;
      end
      S_DONE: begin
        w_done    = 1'b1;
        w_blocked = w_usr_req;
      end
      S_ERR: begin
        w_error   = 1'b1;
        w_blocked = w_usr_req;
      end
      default: begin
        w_blocked = w_usr_req;
      end
    endcase
  end

  assign bus.o_wen         = w_wen;
  assign bus.o_ren         = w_ren;
  assign bus.o_fifo_wdata  = w_busy ? r_result : '0;
  assign bus.o_alu_a       = r_op_a;
  assign bus.o_alu_b       = r_op_b;
  assign bus.o_alu_op      = r_op;
  assign bus.o_busy        = w_busy;
  assign bus.o_usr_blocked = w_blocked;
  assign bus.o_done        = w_done;
  assign bus.o_error       = w_error;

endmodule
`default_nettype wire
